// File: rtl/col_pack128.sv
// col_pack128: packs a word stream into two operand columns for the double-word comparator,
// with a result strobe delayed to line up with the comparator's registered output.
module col_pack128 #(
   parameter int WORD_W  = 32,
   parameter int COL_W   = 128,
   parameter int TAG_W   = 8,
   parameter int CMP_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] in_word,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   output logic [COL_W-1:0]  out_col0,
   output logic [COL_W-1:0]  out_col1,
   output logic              out_valid,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_last,
   output logic              comp_valid,
   output logic [TAG_W-1:0]  comp_tag,
   output logic              comp_last
);
   localparam int WPC = COL_W / WORD_W;
   localparam int IW  = $clog2(2 * WPC);
   localparam logic [IW-1:0] LAST_IDX = IW'(2 * WPC - 1);
   localparam logic [IW-1:0] FILL_END = IW'(WPC - 1);
   typedef enum logic {FILL0, FILL1} state_t;
   state_t             state;
   logic [IW-1:0]      widx;
   logic [2*COL_W-1:0] shadow, merged;
   logic [TAG_W-1:0]   pair_cnt;
   logic [CMP_LAT-1:0] cv, cl;
   logic [TAG_W-1:0]   ct [CMP_LAT];
   logic               accept, issue;
   // merged is the shadow with the current word dropped in; unfilled slots stay zero
   always_comb begin
      accept = in_valid & in_ready;
      issue  = accept & (in_last | (widx == LAST_IDX));
      merged = shadow;
      merged[int'(widx) * WORD_W +: WORD_W] = in_word;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FILL0;
         widx      <= '0;
         shadow    <= '0;
         pair_cnt  <= '0;
         in_ready  <= 1'b0;
         out_col0  <= '0;
         out_col1  <= '0;
         out_valid <= 1'b0;
         out_tag   <= '0;
         out_last  <= 1'b0;
         cv        <= '0;
         cl        <= '0;
         for (int i = 0; i < CMP_LAT; i++) ct[i] <= '0;
      end else begin
         in_ready  <= 1'b1;
         out_valid <= issue;
         if (issue) begin
            out_col0 <= merged[COL_W-1:0];
            out_col1 <= merged[2*COL_W-1:COL_W];
            out_tag  <= pair_cnt;
            out_last <= in_last;
            pair_cnt <= pair_cnt + 1'b1;
            widx     <= '0;
            shadow   <= '0;
            state    <= FILL0;
         end else if (accept) begin
            shadow <= merged;
            widx   <= widx + 1'b1;
            state  <= (widx == FILL_END) ? FILL1 : state;
         end
         // comparator-latency delay line for the result strobe
         cv[0] <= out_valid;
         cl[0] <= out_last;
         ct[0] <= out_tag;
         for (int i = 1; i < CMP_LAT; i++) begin
            cv[i] <= cv[i-1];
            cl[i] <= cl[i-1];
            ct[i] <= ct[i-1];
         end
      end
   end
   assign comp_valid = cv[CMP_LAT-1];
   assign comp_last  = cl[CMP_LAT-1];
   assign comp_tag   = ct[CMP_LAT-1];
endmodule

// File: tb/tb_col_pack128.sv
// tb_col_pack128: directed vector table plus hand sequences for reset, back-to-back and wrap cases.
module tb_col_pack128;
   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, in_last;
   logic [31:0]  in_word;
   logic [127:0] out_col0, out_col1;
   logic         out_valid, out_last, comp_valid, comp_last;
   logic [7:0]   out_tag, comp_tag;
   always #5 clk = ~clk;
   col_pack128 dut (
      .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
      .in_last(in_last), .out_col0(out_col0), .out_col1(out_col1), .out_valid(out_valid),
      .out_tag(out_tag), .out_last(out_last), .comp_valid(comp_valid), .comp_tag(comp_tag),
      .comp_last(comp_last)
   );
   typedef struct {
      int               n;
      bit               last;
      bit               gap;
      logic [7:0][31:0] w;
      logic [127:0]     c0;
      logic [127:0]     c1;
   } vec_t;
   vec_t         vecs [5];
   int           n_chk = 0, n_fail = 0;
   logic [7:0]   exp_tag = '0;
   logic [127:0] e0, e1, p0, p1;
   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic feed(input logic [31:0] w, input logic l, input bit gap);
      if (gap) begin
         in_valid = 1'b0;
         repeat ($urandom_range(1, 10)) begin
            tick;
            chk("gap_no_issue", 256'(out_valid), 256'(0));
         end
      end
      in_valid = 1'b1;
      in_word  = w;
      in_last  = l;
      tick;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask
   task automatic check_zero(input string nm);
      chk({nm, ".in_ready"}, 256'(in_ready), 256'(0));
      chk({nm, ".col0"}, 256'(out_col0), 256'(0));
      chk({nm, ".col1"}, 256'(out_col1), 256'(0));
      chk({nm, ".valid"}, 256'(out_valid), 256'(0));
      chk({nm, ".tag"}, 256'(out_tag), 256'(0));
      chk({nm, ".last"}, 256'(out_last), 256'(0));
      chk({nm, ".comp_valid"}, 256'(comp_valid), 256'(0));
      chk({nm, ".comp_tag"}, 256'(comp_tag), 256'(0));
      chk({nm, ".comp_last"}, 256'(comp_last), 256'(0));
   endtask
   task automatic check_issue(input string nm, input logic [127:0] c0, input logic [127:0] c1,
                              input logic l);
      chk({nm, ".valid"}, 256'(out_valid), 256'(1));
      chk({nm, ".col0"}, 256'(out_col0), 256'(c0));
      chk({nm, ".col1"}, 256'(out_col1), 256'(c1));
      chk({nm, ".tag"}, 256'(out_tag), 256'(exp_tag));
      chk({nm, ".last"}, 256'(out_last), 256'(l));
      tick;
      chk({nm, ".pulse_end"}, 256'(out_valid), 256'(0));
      chk({nm, ".comp_valid"}, 256'(comp_valid), 256'(1));
      chk({nm, ".comp_tag"}, 256'(comp_tag), 256'(exp_tag));
      chk({nm, ".comp_last"}, 256'(comp_last), 256'(l));
      chk({nm, ".hold0"}, 256'(out_col0), 256'(c0));
      chk({nm, ".hold1"}, 256'(out_col1), 256'(c1));
      tick;
      chk({nm, ".comp_end"}, 256'(comp_valid), 256'(0));
      exp_tag++;
   endtask
   initial begin
      vecs[0] = '{8, 1'b0, 1'b0,
                  256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001,
                  128'h00000004_00000003_00000002_00000001,
                  128'h00000008_00000007_00000006_00000005};
      vecs[1] = '{5, 1'b1, 1'b0,
                  256'h0000000E_0000000D_0000000C_0000000B_0000000A,
                  128'h0000000D_0000000C_0000000B_0000000A,
                  128'h0000000E};
      vecs[2] = '{8, 1'b0, 1'b1,
                  256'h00000028_00000027_00000026_00000025_00000024_00000023_00000022_00000021,
                  128'h00000024_00000023_00000022_00000021,
                  128'h00000028_00000027_00000026_00000025};
      vecs[3] = '{8, 1'b1, 1'b1,
                  256'h00000038_00000037_00000036_00000035_00000034_00000033_00000032_00000031,
                  128'h00000034_00000033_00000032_00000031,
                  128'h00000038_00000037_00000036_00000035};
      vecs[4] = '{3, 1'b1, 1'b1,
                  256'h00000053_00000052_00000051,
                  128'h00000053_00000052_00000051,
                  128'h0};
      rst = 1'b1;
      in_valid = 1'b0;
      in_last = 1'b0;
      in_word = '0;
      repeat (2) tick;
      check_zero("reset");
      rst = 1'b0;
      tick;
      chk("ready_after_reset", 256'(in_ready), 256'(1));
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < vecs[k].n; i++) begin
            feed(vecs[k].w[i], vecs[k].last && (i == vecs[k].n - 1), vecs[k].gap && (i > 0));
            if (i < vecs[k].n - 1) chk("no_early_issue", 256'(out_valid), 256'(0));
         end
         check_issue($sformatf("vec%0d", k), vecs[k].c0, vecs[k].c1, vecs[k].last);
      end
      // full pair immediately followed by a one-word closing pair
      for (int i = 0; i < 7; i++) feed(32'h40 + 32'(i), 1'b0, 1'b0);
      in_valid = 1'b1;
      in_word  = 32'h47;
      tick;
      in_word  = 32'hFF;
      in_last  = 1'b1;
      chk("b2b.valid0", 256'(out_valid), 256'(1));
      chk("b2b.tag0", 256'(out_tag), 256'(exp_tag));
      chk("b2b.col1_0", 256'(out_col1), 256'(128'h00000047_00000046_00000045_00000044));
      chk("b2b.last0", 256'(out_last), 256'(0));
      tick;
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("b2b.valid1", 256'(out_valid), 256'(1));
      chk("b2b.tag1", 256'(out_tag), 256'(exp_tag + 8'd1));
      chk("b2b.col0_1", 256'(out_col0), 256'(128'hFF));
      chk("b2b.col1_1", 256'(out_col1), 256'(0));
      chk("b2b.last1", 256'(out_last), 256'(1));
      chk("b2b.comp_valid0", 256'(comp_valid), 256'(1));
      chk("b2b.comp_tag0", 256'(comp_tag), 256'(exp_tag));
      tick;
      chk("b2b.valid_end", 256'(out_valid), 256'(0));
      chk("b2b.comp_valid1", 256'(comp_valid), 256'(1));
      chk("b2b.comp_tag1", 256'(comp_tag), 256'(exp_tag + 8'd1));
      chk("b2b.comp_last1", 256'(comp_last), 256'(1));
      exp_tag += 8'd2;
      // reset in the middle of a pair discards it
      for (int i = 0; i < 6; i++) feed(32'h60 + 32'(i), 1'b0, 1'b0);
      rst = 1'b1;
      tick;
      check_zero("midreset");
      tick;
      rst = 1'b0;
      tick;
      chk("midreset.ready", 256'(in_ready), 256'(1));
      exp_tag = '0;
      for (int i = 0; i < 8; i++) begin
         feed(32'h10 + 32'(i), 1'b0, 1'b0);
         if (i < 7) chk("midreset.no_issue", 256'(out_valid), 256'(0));
      end
      check_issue("after_reset", 128'h00000013_00000012_00000011_00000010,
                  128'h00000017_00000016_00000015_00000014, 1'b0);
      // 257 back-to-back pairs: tag wrap and column stability while filling
      rst = 1'b1;
      tick;
      rst = 1'b0;
      tick;
      exp_tag = '0;
      p0 = '0;
      p1 = '0;
      in_valid = 1'b1;
      for (int p = 0; p < 257; p++) begin
         for (int i = 0; i < 8; i++) begin
            in_word = {16'(p), 16'(i)};
            if (i < 4) e0[32*i +: 32] = in_word;
            else e1[32*(i-4) +: 32] = in_word;
            tick;
            if (i < 7) begin
               chk("stream.no_issue", 256'(out_valid), 256'(0));
               chk("stream.hold", {p1, p0}, {out_col1, out_col0});
            end else begin
               chk("stream.valid", 256'(out_valid), 256'(1));
               chk("stream.cols", {out_col1, out_col0}, {e1, e0});
               chk("stream.tag", 256'(out_tag), 256'(exp_tag));
               if (p == 256) chk("stream.wrap_tag", 256'(out_tag), 256'(0));
               exp_tag++;
               p0 = e0;
               p1 = e1;
            end
         end
      end
      in_valid = 1'b0;
      tick;
      chk("stream.final_comp", 256'(comp_valid), 256'(1));
      chk("stream.final_comp_tag", 256'(comp_tag), 256'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
